demux_5bit_1to2_buf: RTL and testbench

- Registered 1-to-2 demultiplexer: the fan-out counterpart of the 5-bit 2:1 selector used on the register-address path.
- Accepts one WIDTH-bit word per handshake, plus a select bit.
- Steers the word into one of two per-channel FIFOs; each FIFO drains through its own valid/ready port.
- Counts words delivered per channel, for debug and for the bench.

---
 rtl/demux_5bit_1to2_buf.sv | 88 ++++++++
 tb/tb_demux_5bit_1to2_buf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux_5bit_1to2_buf.sv
// Registered 1-to-2 demultiplexer: each input word is steered into one of two
// per-channel FIFOs, each drained through its own valid/ready port with a pop counter.
module demux_5bit_1to2_buf #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [1:0]             rdy, vld, full, push, pop;
    logic [1:0][WIDTH-1:0]  head;
    logic [1:0][CNT_W-1:0]  cnt;

    assign rdy = {out1_ready, out0_ready};

    // Based on registered occupancy only, so a full channel never passes a word through.
    assign in_ready = !full[in_sel] && !reset;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
        logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
        logic [OW-1:0]               occ_q, occ_d;
        logic [CNT_W-1:0]            cnt_q, cnt_d;

        assign push[g] = in_valid && in_ready && (in_sel == 1'(g));
        assign vld[g]  = (occ_q != '0);
        assign full[g] = (occ_q == OW'(DEPTH));
        assign pop[g]  = vld[g] && rdy[g];
        // Empty channels present zero rather than stale storage.
        assign head[g] = vld[g] ? mem_q[rd_q] : '0;
        assign cnt[g]  = cnt_q;

        always_comb begin
            mem_d = mem_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push[g]) begin
                mem_d[wr_q] = in_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop[g]) begin
                rd_d  = rd_q + AW'(1);
                cnt_d = cnt_q + CNT_W'(1);
            end
            occ_d = occ_q + OW'(push[g]) - OW'(pop[g]);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                occ_q <= '0;
                cnt_q <= '0;
            end else begin
                mem_q <= mem_d;
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                occ_q <= occ_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = vld[0];
    assign out1_valid = vld[1];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_5bit_1to2_buf.sv
// Bench for demux_5bit_1to2_buf: directed vector table, counter-wrap and reset
// sequences, then random traffic, all cross-checked against a queue-based model.
module tb_demux_5bit_1to2_buf;
    localparam int WIDTH = 5;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_valid, in_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic             out0_valid, out0_ready, out1_valid, out1_ready;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    demux_5bit_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus pop counts.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    int mc0 = 0;
    int mc1 = 0;

    typedef struct {
        bit rst, vld, sel;
        logic [WIDTH-1:0] d;
        bit r0, r1;
        bit ir, v0;
        logic [WIDTH-1:0] d0;
        bit v1;
        logic [WIDTH-1:0] d1;
        int c0, c1;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit vld, bit sel, logic [WIDTH-1:0] d, bit r0, bit r1,
                                bit ir, bit v0, logic [WIDTH-1:0] d0, bit v1,
                                logic [WIDTH-1:0] d1, int c0, int c1);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
        v.ir = ir; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst, bit vld, bit sel, logic [WIDTH-1:0] d, bit r0, bit r1);
        reset = rst; in_valid = vld; in_sel = sel; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
    endtask

    task automatic check_model();
        int sz;
        sz = (in_sel ? mq1.size() : mq0.size());
        chk("m_in_ready", 32'(in_ready), 32'(!reset && sz < DEPTH));
        chk("m_v0", 32'(out0_valid), 32'(mq0.size() > 0));
        chk("m_v1", 32'(out1_valid), 32'(mq1.size() > 0));
        chk("m_d0", 32'(out0_data), mq0.size() > 0 ? 32'(mq0[0]) : 32'd0);
        chk("m_d1", 32'(out1_data), mq1.size() > 0 ? 32'(mq1[0]) : 32'd0);
        chk("m_cnt0", 32'(cnt0), 32'(mc0 % 256));
        chk("m_cnt1", 32'(cnt1), 32'(mc1 % 256));
    endtask

    // Advance the model with the currently driven inputs, then cross the clock edge.
    task automatic tick();
        bit acc;
        if (reset) begin
            mq0.delete(); mq1.delete(); mc0 = 0; mc1 = 0;
        end else begin
            acc = in_valid && ((in_sel ? mq1.size() : mq0.size()) < DEPTH);
            if (out0_ready && mq0.size() > 0) begin void'(mq0.pop_front()); mc0++; end
            if (out1_ready && mq1.size() > 0) begin void'(mq1.pop_front()); mc1++; end
            if (acc) begin
                if (in_sel) mq1.push_back(in_data); else mq0.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(bit rst, bit vld, bit sel, logic [WIDTH-1:0] d, bit r0, bit r1);
        drive(rst, vld, sel, d, r0, r1);
        check_model();
        tick();
    endtask

    initial begin
        // Directed vectors; expected outputs are those seen before the row's clock edge.
        //                rst vld sel d      r0 r1  ir v0 d0     v1 d1     c0 c1
        vq.push_back(mk(1, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00, 0, 5'h00, 0, 0));
        vq.push_back(mk(0, 1, 0, 5'h00, 1, 1, 1, 0, 5'h00, 0, 5'h00, 0, 0));
        vq.push_back(mk(0, 1, 1, 5'h1F, 1, 1, 1, 1, 5'h00, 0, 5'h00, 0, 0));
        vq.push_back(mk(0, 0, 0, 5'h00, 1, 1, 1, 0, 5'h00, 1, 5'h1F, 1, 0));
        vq.push_back(mk(0, 0, 0, 5'h00, 0, 0, 1, 0, 5'h00, 0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 0, 5'h03, 0, 0, 1, 0, 5'h00, 0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 0, 5'h05, 0, 0, 1, 1, 5'h03, 0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 0, 5'h07, 0, 0, 0, 1, 5'h03, 0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 1, 5'h1A, 0, 1, 1, 1, 5'h03, 0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 0, 5'h07, 0, 1, 0, 1, 5'h03, 1, 5'h1A, 1, 1));
        vq.push_back(mk(0, 1, 0, 5'h07, 1, 0, 0, 1, 5'h03, 0, 5'h00, 1, 2));
        vq.push_back(mk(0, 1, 0, 5'h07, 1, 0, 1, 1, 5'h05, 0, 5'h00, 2, 2));
        vq.push_back(mk(0, 0, 0, 5'h00, 1, 0, 1, 1, 5'h07, 0, 5'h00, 3, 2));
        vq.push_back(mk(0, 0, 0, 5'h00, 0, 0, 1, 0, 5'h00, 0, 5'h00, 4, 2));
        vq.push_back(mk(0, 1, 1, 5'h0F, 0, 0, 1, 0, 5'h00, 0, 5'h00, 4, 2));
        vq.push_back(mk(0, 1, 1, 5'h10, 0, 1, 1, 0, 5'h00, 1, 5'h0F, 4, 2));
        vq.push_back(mk(0, 0, 1, 5'h00, 0, 0, 1, 0, 5'h00, 1, 5'h10, 4, 3));
        vq.push_back(mk(0, 0, 1, 5'h00, 0, 1, 1, 0, 5'h00, 1, 5'h10, 4, 3));
        vq.push_back(mk(0, 0, 0, 5'h00, 0, 0, 1, 0, 5'h00, 0, 5'h00, 4, 4));

        drive(1, 0, 0, 5'h00, 0, 0);
        tick();
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].vld, vq[i].sel, vq[i].d, vq[i].r0, vq[i].r1);
            chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
            chk($sformatf("t%0d_v0", i), 32'(out0_valid), 32'(vq[i].v0));
            chk($sformatf("t%0d_d0", i), 32'(out0_data), 32'(vq[i].d0));
            chk($sformatf("t%0d_v1", i), 32'(out1_valid), 32'(vq[i].v1));
            chk($sformatf("t%0d_d1", i), 32'(out1_data), 32'(vq[i].d1));
            chk($sformatf("t%0d_cnt0", i), 32'(cnt0), 32'(vq[i].c0));
            chk($sformatf("t%0d_cnt1", i), 32'(cnt1), 32'(vq[i].c1));
            check_model();
            tick();
        end

        // Counter wrap: stream 256 words through channel 0 from a clean reset.
        cyc(1, 0, 0, 5'h00, 0, 0);
        for (int i = 0; i < 258; i++) begin
            drive(0, i < 256, 0, 5'(i), 1, 0);
            if (i == 256) chk("wrap_cnt0_255", 32'(cnt0), 32'd255);
            if (i == 257) chk("wrap_cnt0_0", 32'(cnt0), 32'd0);
            check_model();
            tick();
        end

        // Fill both channels, then reset mid-operation.
        cyc(0, 1, 0, 5'h11, 0, 0);
        cyc(0, 1, 0, 5'h12, 0, 0);
        cyc(0, 1, 1, 5'h13, 0, 0);
        cyc(0, 1, 1, 5'h14, 0, 0);
        cyc(1, 0, 0, 5'h00, 0, 0);
        drive(0, 0, 0, 5'h00, 1, 1);
        chk("rst_v0", 32'(out0_valid), 32'd0);
        chk("rst_v1", 32'(out1_valid), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        check_model();
        tick();
        for (int i = 0; i < 3; i++) cyc(0, 0, i[0], 5'h00, 1, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                5'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
